// File: rtl/ext_bus_pkg.sv
// Shared constants for the external peripheral bus arbiter.
package ext_bus_pkg;

    localparam int unsigned EXT_ADDR_W   = 19;
    localparam int unsigned EXT_DATA_W   = 16;
    localparam int unsigned EXT_BE_W     = 2;
    localparam logic [15:0] EXT_ERR_DATA = 16'hDEAD;

    // Arbiter FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: the requester that was not granted last wins a tie.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_i,      // 1 = requester 1 was granted last
    output logic [1:0] winner_c_o   // one-hot, 00 when nothing requested
);

    // Single requester wins outright; a tie goes away from the last owner
    always_comb begin
        winner_c_o = req_i;
        if (req_i == 2'b11) begin
            winner_c_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/external_bus_arbiter.sv
// Two-master round-robin arbiter onto the shared external peripheral bus,
// with registered command, acknowledge return and a wait timeout.
module external_bus_arbiter #(
    parameter int unsigned ADDR_W   = ext_bus_pkg::EXT_ADDR_W,
    parameter int unsigned DATA_W   = ext_bus_pkg::EXT_DATA_W,
    parameter int unsigned BE_W     = ext_bus_pkg::EXT_BE_W,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ext_bus_pkg::EXT_ERR_DATA)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              m0_bus_enable,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byte_enable,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic              m0_acknowledge,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_error,
    input  logic              m1_bus_enable,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byte_enable,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic              m1_acknowledge,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              m1_error,
    output logic              bus_enable,
    output logic [ADDR_W-1:0] bus_address,
    output logic [BE_W-1:0]   bus_byte_enable,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic              bus_acknowledge,
    input  logic [DATA_W-1:0] bus_read_data,
    output logic [1:0]        grant
);

    import ext_bus_pkg::*;

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    logic [1:0]        state_q, state_d;
    logic              bus_en_q, bus_en_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic              bus_rw_q, bus_rw_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        winner_c;

    rr_arbiter_2 u_rr (
        .req_i      ({m1_bus_enable, m0_bus_enable}),
        .last_i     (last_q),
        .winner_c_o (winner_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        bus_en_d    = bus_en_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_rw_d    = bus_rw_q;
        bus_wdata_d = bus_wdata_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (winner_c != 2'b00) begin
                    bus_en_d    = 1'b1;
                    bus_addr_d  = winner_c[1] ? m1_address     : m0_address;
                    bus_be_d    = winner_c[1] ? m1_byte_enable : m0_byte_enable;
                    bus_rw_d    = winner_c[1] ? m1_rw          : m0_rw;
                    bus_wdata_d = winner_c[1] ? m1_write_data  : m0_write_data;
                    grant_d     = winner_c;
                    last_d      = winner_c[1];
                    cnt_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (bus_acknowledge) begin
                    if (grant_q[1]) rdata1_d = bus_read_data;
                    else            rdata0_d = bus_read_data;
                    ack_d    = grant_q;
                    bus_en_d = 1'b0;
                    state_d  = DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    if (grant_q[1]) rdata1_d = ERR_DATA;
                    else            rdata0_d = ERR_DATA;
                    ack_d    = grant_q;
                    err_d    = grant_q;
                    bus_en_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                bus_en_d = 1'b0;
                grant_d  = 2'b00;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            bus_en_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_rw_q    <= 1'b0;
            bus_wdata_q <= '0;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            bus_en_q    <= bus_en_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_rw_q    <= bus_rw_d;
            bus_wdata_q <= bus_wdata_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus_enable      = bus_en_q;
    assign bus_address     = bus_addr_q;
    assign bus_byte_enable = bus_be_q;
    assign bus_rw          = bus_rw_q;
    assign bus_write_data  = bus_wdata_q;
    assign grant           = grant_q;
    assign m0_acknowledge  = ack_q[0];
    assign m1_acknowledge  = ack_q[1];
    assign m0_error        = err_q[0];
    assign m1_error        = err_q[1];
    assign m0_read_data    = rdata0_q;
    assign m1_read_data    = rdata1_q;

endmodule

// File: tb/tb_external_bus_arbiter.sv
// Bench for external_bus_arbiter: directed vector table, corner sequences and
// a randomized run against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_external_bus_arbiter;

    localparam int unsigned T  = 4;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic          m0_bus_enable, m1_bus_enable;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byte_enable, m1_byte_enable;
    logic          m0_rw, m1_rw;
    logic [DW-1:0] m0_write_data, m1_write_data;
    logic          m0_acknowledge, m1_acknowledge;
    logic [DW-1:0] m0_read_data, m1_read_data;
    logic          m0_error, m1_error;
    logic          bus_enable;
    logic [AW-1:0] bus_address;
    logic [BW-1:0] bus_byte_enable;
    logic          bus_rw;
    logic [DW-1:0] bus_write_data;
    logic          bus_acknowledge;
    logic [DW-1:0] bus_read_data;
    logic [1:0]    grant;

    always #5 clk_clk = ~clk_clk;

    external_bus_arbiter #(.TIMEOUT(T)) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .m0_bus_enable   (m0_bus_enable),
        .m0_address      (m0_address),
        .m0_byte_enable  (m0_byte_enable),
        .m0_rw           (m0_rw),
        .m0_write_data   (m0_write_data),
        .m0_acknowledge  (m0_acknowledge),
        .m0_read_data    (m0_read_data),
        .m0_error        (m0_error),
        .m1_bus_enable   (m1_bus_enable),
        .m1_address      (m1_address),
        .m1_byte_enable  (m1_byte_enable),
        .m1_rw           (m1_rw),
        .m1_write_data   (m1_write_data),
        .m1_acknowledge  (m1_acknowledge),
        .m1_read_data    (m1_read_data),
        .m1_error        (m1_error),
        .bus_enable      (bus_enable),
        .bus_address     (bus_address),
        .bus_byte_enable (bus_byte_enable),
        .bus_rw          (bus_rw),
        .bus_write_data  (bus_write_data),
        .bus_acknowledge (bus_acknowledge),
        .bus_read_data   (bus_read_data),
        .grant           (grant)
    );

    // Peripheral: acknowledges in the ack_delay-th cycle of bus_enable (0 = combinational)
    int            en_cnt;
    int            ack_delay;
    logic          stray_ack;
    logic [DW-1:0] periph_data;

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) en_cnt <= 0;
        else                en_cnt <= bus_enable ? en_cnt + 1 : 0;
    end

    assign bus_acknowledge = bus_enable ? (en_cnt == ack_delay) : stray_ack;
    assign bus_read_data   = periph_data;

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic drive(input int m, input logic en, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic rw, input logic [DW-1:0] wd);
        if (m == 0) begin
            m0_bus_enable = en; m0_address = a; m0_byte_enable = be; m0_rw = rw; m0_write_data = wd;
        end else begin
            m1_bus_enable = en; m1_address = a; m1_byte_enable = be; m1_rw = rw; m1_write_data = wd;
        end
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        stray_ack = 1'b0;
        ack_delay = 0;
        tick();
        tick();
        reset_reset_n = 1'b1;
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_acknowledge : m1_acknowledge;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? m0_error : m1_error;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int m);
        return (m == 0) ? m0_read_data : m1_read_data;
    endfunction

    // Directed single-transaction vectors; exp_lat counts cycles from request
    // to acknowledge: 2 + min(delay, T-1)
    typedef struct {
        int            m;
        logic          rw;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] pdata;
        int            delay;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt[6];

    // Random-phase model state
    logic          rq[2];
    logic [AW-1:0] ra[2];
    logic [BW-1:0] rbe[2];
    logic          rrw[2];
    logic [DW-1:0] rwd[2];
    logic          busy, err_e;
    int            cur_m, rise_c, end_c, ack_c, free_c, last_win, c, d;
    logic [AW-1:0] cap_a;
    logic [BW-1:0] cap_be;
    logic          cap_rw;
    logic [DW-1:0] cap_wd;
    logic [DW-1:0] rdata_e;

    initial begin
        vec_t v;
        int   lat, en_cycles, nrise, win;
        logic seen, prev_en, exp_en, in_grant, is_ack;
        logic [1:0] order[4];
        int   rise_k[4];
        logic [1:0] exp_g;

        n_vec = 0;
        n_err = 0;

        vt[0] = '{0, 1'b0, 19'h00004, 2'b11, 16'h1234, 16'h0000, 0,   2, 1'b0, 16'h0000};
        vt[1] = '{1, 1'b1, 19'h7FFFF, 2'b10, 16'h0000, 16'hBEEF, 0,   2, 1'b0, 16'hBEEF};
        vt[2] = '{0, 1'b1, 19'h12345, 2'b01, 16'h0000, 16'hCAFE, 2,   4, 1'b0, 16'hCAFE};
        vt[3] = '{1, 1'b1, 19'h00100, 2'b11, 16'h0000, 16'h5A5A, 3,   5, 1'b0, 16'h5A5A};
        vt[4] = '{0, 1'b1, 19'h00003, 2'b11, 16'h0000, 16'h1111, 4,   5, 1'b1, 16'hDEAD};
        vt[5] = '{1, 1'b0, 19'h40000, 2'b01, 16'hFFFF, 16'h2222, 100, 5, 1'b1, 16'hDEAD};

        // Reset state, checked before any clock edge
        reset_reset_n = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        stray_ack   = 1'b0;
        ack_delay   = 0;
        periph_data = '0;
        #2;
        chk("rst_bus_enable", 64'(bus_enable), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_acks", 64'({m0_acknowledge, m1_acknowledge, m0_error, m1_error}), 64'(0));
        chk("rst_rdata", 64'({m0_read_data, m1_read_data}), 64'(0));
        chk("rst_bus_cmd", 64'({bus_address, bus_byte_enable, bus_rw, bus_write_data}), 64'(0));
        tick();
        tick();
        reset_reset_n = 1'b1;
        tick();

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            v = vt[i];
            ack_delay   = v.delay;
            periph_data = v.pdata;
            drive(v.m, 1'b1, v.addr, v.be, v.rw, v.wdata);
            seen = 1'b0; lat = 0; en_cycles = 0;
            for (int k = 1; k <= 12; k++) begin
                if (!seen) begin
                    tick();
                    if (k == 1) begin
                        chk("vec_first_enable", 64'(bus_enable), 64'(1));
                        chk("vec_bus_cmd", 64'({bus_address, bus_byte_enable, bus_rw, bus_write_data}),
                            64'({v.addr, v.be, v.rw, v.wdata}));
                        chk("vec_grant", 64'(grant), 64'((v.m == 1) ? 2'b10 : 2'b01));
                    end
                    if (bus_enable) en_cycles++;
                    if (ack_of(v.m)) begin
                        seen = 1'b1;
                        lat  = k;
                        chk("vec_rdata", 64'(rdata_of(v.m)), 64'(v.exp_rdata));
                        chk("vec_error", 64'(err_of(v.m)), 64'(v.exp_err));
                        chk("vec_other_ack", 64'({ack_of(1 - v.m), err_of(1 - v.m)}), 64'(0));
                        drive(v.m, 1'b0, '0, '0, 1'b0, '0);
                    end
                end
            end
            chk("vec_latency", 64'(lat), 64'(v.exp_lat));
            chk("vec_enable_cycles", 64'(en_cycles), 64'(v.exp_lat - 1));
            if (!seen) drive(v.m, 1'b0, '0, '0, 1'b0, '0);
            tick();
            chk("vec_idle_after", 64'({grant, bus_enable}), 64'(0));
        end

        // Command is captured at grant: later input changes do not reach the bus
        ack_delay   = 3;
        periph_data = 16'h0F0F;
        drive(0, 1'b1, 19'h2, 2'b11, 1'b0, 16'hAAAA);
        tick();
        chk("held_addr_k1", 64'(bus_address), 64'(19'h2));
        drive(0, 1'b1, 19'h6, 2'b01, 1'b1, 16'h5555);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("held_enable", 64'(bus_enable), 64'(1));
            chk("held_cmd", 64'({bus_address, bus_byte_enable, bus_rw, bus_write_data}),
                64'({19'h2, 2'b11, 1'b0, 16'hAAAA}));
        end
        tick();
        chk("held_ack", 64'(m0_acknowledge), 64'(1));
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        tick();

        // Contention after reset: strict alternation starting with m0, 3 cycles apart
        do_reset();
        ack_delay = 0;
        drive(0, 1'b1, 19'h100, 2'b11, 1'b1, 16'h0);
        drive(1, 1'b1, 19'h200, 2'b11, 1'b1, 16'h0);
        prev_en = 1'b0; nrise = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("cont_no_overlap", 64'({grant == 2'b11, m0_acknowledge & m1_acknowledge}), 64'(0));
            if (bus_enable && !prev_en) begin
                if (nrise < 4) begin
                    order[nrise]  = grant;
                    rise_k[nrise] = k;
                end
                nrise++;
            end
            prev_en = bus_enable;
        end
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        chk("cont_order0", 64'(order[0]), 64'(2'b01));
        chk("cont_order1", 64'(order[1]), 64'(2'b10));
        chk("cont_order2", 64'(order[2]), 64'(2'b01));
        chk("cont_order3", 64'(order[3]), 64'(2'b10));
        chk("cont_first_k", 64'(rise_k[0]), 64'(1));
        for (int j = 1; j < 4; j++) chk("cont_spacing", 64'(rise_k[j] - rise_k[j-1]), 64'(3));
        tick();
        tick();

        // Reset in WAIT of an m0 transaction: outputs clear without a clock edge
        ack_delay = 100;
        drive(0, 1'b1, 19'h55, 2'b11, 1'b1, 16'h0);
        tick();
        tick();
        chk("rmid_pre_enable", 64'(bus_enable), 64'(1));
        reset_reset_n = 1'b0;
        #1;
        chk("rmid_enable", 64'(bus_enable), 64'(0));
        chk("rmid_grant", 64'(grant), 64'(0));
        chk("rmid_acks", 64'({m0_acknowledge, m0_error, m1_acknowledge, m1_error}), 64'(0));
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        reset_reset_n = 1'b1;
        ack_delay = 0;
        drive(0, 1'b1, 19'h11, 2'b11, 1'b1, 16'h0);
        drive(1, 1'b1, 19'h22, 2'b11, 1'b1, 16'h0);
        tick();
        chk("rmid_tie_m0", 64'(grant), 64'(2'b01));
        tick();
        chk("rmid_m0_ack", 64'({m0_acknowledge, m1_acknowledge}), 64'(2'b10));
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        tick();
        chk("rmid_then_m1", 64'(grant), 64'(2'b10));
        tick();
        chk("rmid_m1_ack", 64'({m0_acknowledge, m1_acknowledge}), 64'(2'b01));
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        tick();

        // Randomized traffic against a transaction-timeline model
        do_reset();
        busy = 1'b0; free_c = 0; last_win = 1; c = 0;
        cur_m = 0; rise_c = 0; end_c = 0; ack_c = 0; err_e = 1'b0; rdata_e = '0;
        cap_a = '0; cap_be = '0; cap_rw = 1'b0; cap_wd = '0;
        for (int m = 0; m < 2; m++) begin
            rq[m] = 1'b0; ra[m] = '0; rbe[m] = '0; rrw[m] = 1'b0; rwd[m] = '0;
        end
        for (int it = 0; it < 600; it++) begin
            tick();
            c++;
            exp_en   = busy && (c >= rise_c) && (c <= end_c);
            in_grant = busy && (c >= rise_c) && (c <= ack_c);
            is_ack   = busy && (c == ack_c);
            exp_g    = in_grant ? ((cur_m == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_bus_enable", 64'(bus_enable), 64'(exp_en));
            chk("rnd_grant", 64'(grant), 64'(exp_g));
            chk("rnd_m0_ack", 64'(m0_acknowledge), 64'(is_ack && cur_m == 0));
            chk("rnd_m1_ack", 64'(m1_acknowledge), 64'(is_ack && cur_m == 1));
            chk("rnd_m0_err", 64'(m0_error), 64'(is_ack && cur_m == 0 && err_e));
            chk("rnd_m1_err", 64'(m1_error), 64'(is_ack && cur_m == 1 && err_e));
            if (exp_en)
                chk("rnd_bus_cmd", 64'({bus_address, bus_byte_enable, bus_rw, bus_write_data}),
                    64'({cap_a, cap_be, cap_rw, cap_wd}));
            if (is_ack) begin
                chk("rnd_rdata", 64'(rdata_of(cur_m)), 64'(rdata_e));
                busy      = 1'b0;
                rq[cur_m] = 1'b0;
                free_c    = c + 1;
            end

            stray_ack = bus_enable ? 1'b0 : 1'($urandom_range(0, 1));
            for (int m = 0; m < 2; m++) begin
                if (!rq[m]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rq[m] = 1'b1; ra[m] = AW'($urandom); rbe[m] = BW'($urandom);
                        rrw[m] = 1'($urandom); rwd[m] = DW'($urandom);
                    end
                end else if (busy && cur_m == m && $urandom_range(0, 1) == 1) begin
                    ra[m] = AW'($urandom); rbe[m] = BW'($urandom);
                    rrw[m] = 1'($urandom); rwd[m] = DW'($urandom);
                end
                drive(m, rq[m], ra[m], rbe[m], rrw[m], rwd[m]);
            end

            if (!busy && c >= free_c && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) win = (last_win == 1) ? 0 : 1;
                else                win = rq[0] ? 0 : 1;
                busy   = 1'b1;
                cur_m  = win;
                rise_c = c + 1;
                cap_a  = ra[win]; cap_be = rbe[win]; cap_rw = rrw[win]; cap_wd = rwd[win];
                d      = int'($urandom_range(0, 6));
                end_c  = rise_c + ((d < int'(T)) ? d : int'(T) - 1);
                ack_c  = end_c + 1;
                err_e  = (d >= int'(T));
                periph_data = DW'($urandom);
                rdata_e  = err_e ? 16'hDEAD : periph_data;
                ack_delay = d;
                last_win  = win;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/external_bus_arbiter.md
Name: external_bus_arbiter

Overview:
Two-master arbiter for the 16-bit external peripheral bus (19-bit address, byte enables, rw, acknowledge handshake).
- Each master presents a transaction on its own port set. The arbiter grants one master at a time using round-robin priority, registers the command onto the shared bus, and waits for acknowledge.
- It returns the read data and a one-cycle acknowledge to the granted master.
- A timeout terminates transactions that the peripheral never acknowledges.
- Sits between CPU-side bus masters and peripherals such as the external-bus register block.

Parameters:
ADDR_W, 19, address width
DATA_W, 16, data width
BE_W, 2, byte-enable width
TIMEOUT, 255, cycles in WAIT before forced termination; 0 disables the timeout
ERR_DATA, 16'hDEAD, read_data returned on a timeout

Ports:
clk_clk  in  1  clock
reset_reset_n  in  1  asynchronous active-low reset
m0_bus_enable, m1_bus_enable  in  1  master request; held until that master's acknowledge
m0_address, m1_address  in  ADDR_W  master address
m0_byte_enable, m1_byte_enable  in  BE_W  master byte enables
m0_rw, m1_rw  in  1  1 = read, 0 = write
m0_write_data, m1_write_data  in  DATA_W  master write data
m0_acknowledge, m1_acknowledge  out  1  one-cycle completion pulse
m0_read_data, m1_read_data  out  DATA_W  registered read data, valid while acknowledge is high
m0_error, m1_error  out  1  pulses with acknowledge when the transaction timed out
bus_enable  out  1  shared-bus request
bus_address  out  ADDR_W  shared-bus address
bus_byte_enable  out  BE_W  shared-bus byte enables
bus_rw  out  1  shared-bus direction
bus_write_data  out  DATA_W  shared-bus write data
bus_acknowledge  in  1  peripheral acknowledge; may be combinational from bus_enable
bus_read_data  in  DATA_W  peripheral read data
grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (async, reset_reset_n = 0):
  - state = IDLE.
  - All outputs 0: bus_* = 0, grant = 00, mN_acknowledge = 0, mN_error = 0, mN_read_data = 0.
  - last_grant = 1, so m0 wins the first tie.
  - Timeout counter = 0.
  - Asserting reset mid-transaction drops bus_enable immediately (asynchronously); the transaction is abandoned with no acknowledge.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If any mN_bus_enable is high, pick the winner.
    - Only one requesting: grant it.
    - Both requesting: grant the master that is not last_grant.
  - On that edge:
    - Capture the winner's address, byte_enable, rw and write_data into the bus_* registers.
    - bus_enable <= 1, grant <= winner, last_grant <= winner, counter <= 0.
    - Go to WAIT.
  - No request: stay in IDLE, bus_enable = 0.
- WAIT:
  - bus_* are held constant.
  - If bus_acknowledge = 1:
    - mN_read_data <= bus_read_data (captured on reads; on writes the data is don't-care but still captured).
    - mN_acknowledge <= 1, bus_enable <= 0.
    - Go to DONE.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT - 1:
    - mN_read_data <= ERR_DATA, mN_acknowledge <= 1, mN_error <= 1, bus_enable <= 0.
    - Go to DONE.
  - Else counter <= counter + 1.
  - Counter width is clog2(TIMEOUT+1) and it never wraps.
- DONE (one cycle):
  - The acknowledge/error pulse is visible this cycle.
  - grant <= 00, then return to IDLE.
  - Requests are not sampled in DONE. This guarantees the acknowledged master has deasserted before the next arbitration.
- Latency:
  - Request sampled at edge E: bus_enable is high in cycle E+1.
  - With a combinational peripheral acknowledge, mN_acknowledge is high in cycle E+2.
  - Next grant no earlier than edge E+3.
  - Back-to-back throughput: one transaction per 3 cycles.
- The command is captured at grant. A master changing or dropping its inputs during WAIT does not affect the bus.
- The non-granted master's request is held pending, not lost. Its acknowledge and error stay 0.
- Round-robin guarantee: with both masters requesting continuously, grants strictly alternate.
- A bus_acknowledge arriving in IDLE or DONE is ignored.

Decomposition:
- Shared package ext_bus_pkg holds:
  - FSM state encoding: IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2.
  - ADDR_W, DATA_W and BE_W default constants.
  - ERR_DATA.
- One natural sub-module: rr_arbiter_2. It is combinational: request[1:0] + last_grant -> one-hot winner, reusable elsewhere.
- FSM, command registers and timeout counter stay in the top-level module.

Test Plan:
- Single write: m0 write, address 19'h4, byte_enable 2'b11, data 16'h1234, ack tied to bus_enable -> bus_enable high 1 cycle; bus_address = 19'h4, bus_write_data = 16'h1234; m0_acknowledge pulses 2 cycles after the request; grant = 01 during WAIT.
- Single read: m1 read with bus_read_data = 16'hBEEF -> m1_read_data = 16'hBEEF while m1_acknowledge is high; m0_acknowledge stays 0.
- Contention: both masters request continuously for 4 transactions after reset -> grant order m0, m1, m0, m1; no overlap; 3 cycles per transaction.
- Timeout: TIMEOUT = 4, bus_acknowledge held 0 -> bus_enable high exactly 4 cycles; m0_acknowledge and m0_error pulse together; m0_read_data = 16'hDEAD.
- Reset mid-transaction: reset_reset_n low during WAIT -> bus_enable, grant and acknowledges go 0 immediately, without waiting for a clock edge; after release, the first tie goes to m0.
- Held inputs: m0 changes m0_address from 19'h2 to 19'h6 during WAIT -> bus_address stays 19'h2 until DONE.
